switch_arbiter: RTL

- Round-robin merge arbiter: the reverse direction of the SEL-driven switcher.
- Collects packet streams from NCH channels, grants one channel per packet and forwards its beats on a single registered output.
- Drives OUT_SEL with the granted channel index, so a downstream switcher can route responses back to the same channel.
- Sits between per-channel sources and a shared datapath.

---
 rtl/switch_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/switch_arbiter.sv
// rtl/switch_arbiter.sv - round-robin packet merge arbiter driving a registered output and source select
// Optional lock-release timeout enabled by defining SWITCH_ARB_TIMEOUT_EN.
module switch_arbiter #(
  parameter int NCH     = 8,
  parameter int WIDTH   = 16,
  parameter int SELW    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NCH-1:0]   i_in_valid,
  input  logic [WIDTH-1:0] i_in_data [NCH],
  input  logic [NCH-1:0]   i_in_last,
  output logic [NCH-1:0]   o_in_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_last,
  output logic [SELW-1:0]  o_out_sel,
  input  logic             i_out_ready
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [SELW-1:0]  r_ptr, w_ptr_nxt;
  logic [SELW-1:0]  r_grant, w_grant_nxt;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_any_req;
  logic             w_can_load;
  logic             w_xfer;
  logic             w_timeout;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SELW-1:0]  r_out_sel;

  // Scan from highest offset down so the nearest requester after r_ptr wins.
  always_comb begin
    logic [SELW-1:0] w_idx;
    w_rr_idx  = r_ptr;
    w_any_req = 1'b0;
    w_idx     = r_ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      w_idx = r_ptr + SELW'(i);
      if (i_in_valid[w_idx]) begin
        w_rr_idx  = w_idx;
        w_any_req = 1'b1;
      end
    end
  end

  assign w_can_load = !r_out_valid || i_out_ready;
  assign w_xfer     = (r_state == ST_LOCKED) && i_in_valid[r_grant] && w_can_load;

  always_comb begin
    o_in_ready = '0;
    if (r_state == ST_LOCKED) begin
      o_in_ready[r_grant] = w_can_load;
    end
  end

`ifdef SWITCH_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle_cnt;

  assign w_timeout = (r_state == ST_LOCKED) && !i_in_valid[r_grant] &&
                     (r_idle_cnt == TW'(TIMEOUT - 1));

  // Counts consecutive starved LOCKED cycles; held at zero while IDLE so each lock starts fresh.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idle_cnt <= '0;
    end else if (r_state != ST_LOCKED || i_in_valid[r_grant] || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end
`else
  assign w_timeout = (TIMEOUT < 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant_nxt = w_rr_idx;
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if ((w_xfer && i_in_last[r_grant]) || w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = r_grant + SELW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= i_in_data[r_grant];
      r_out_last  <= i_in_last[r_grant];
      r_out_sel   <= r_grant;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_out_sel   = r_out_sel;

endmodule
